sweep_ctrl: RTL

Sweep sequencer that sits directly upstream of the ADC capture/UART readout stage. It steps the 20-bit divider `counter` word from a start value to a stop value by a fixed increment. At each point it waits a programmable settle time, then runs one capture-and-send handshake (`rd_start`/`rd_ready`) before moving to the next point. The readout stage is unchanged; this block owns its `counter` and `start` inputs.

---
 rtl/sweep_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: steps the readout divider word from start to stop, settling and
// running one rd_start/rd_ready handshake per point, with per-phase timeout.
module sweep_ctrl #(
    parameter int CNT_W    = 20,
    parameter int SETTLE_W = 16,
    parameter int TMO_CYC  = 2_000_000
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                go,
    input  logic                abort,
    input  logic [CNT_W-1:0]    cnt_start,
    input  logic [CNT_W-1:0]    cnt_stop,
    input  logic [CNT_W-1:0]    cnt_step,
    input  logic [SETTLE_W-1:0] settle,
    input  logic                rd_ready,
    output logic [CNT_W-1:0]    counter,
    output logic                rd_start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         pt_idx
);

    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_RDY,
        S_WAIT_CLR,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_counter;
    logic [CNT_W-1:0]    r_stop;
    logic [CNT_W-1:0]    r_step;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] r_set_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic [15:0]         r_pt_idx;
    logic                r_rd_start;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // Extra carry bit makes an overflowing step compare above any stop value.
    logic [CNT_W:0] w_sum;
    logic           w_last;
    logic           w_tmo_hit;

    assign w_sum     = {1'b0, r_counter} + {1'b0, r_step};
    assign w_last    = (r_step == '0) || (w_sum > {1'b0, r_stop});
    assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_counter  <= '0;
            r_stop     <= '0;
            r_step     <= '0;
            r_settle   <= '0;
            r_set_cnt  <= '0;
            r_tmo      <= '0;
            r_pt_idx   <= '0;
            r_rd_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_rd_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_state    <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_counter <= cnt_start;
                        r_pt_idx  <= '0;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                        r_stop    <= cnt_stop;
                        r_step    <= cnt_step;
                        r_settle  <= settle;
                        r_set_cnt <= settle;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_set_cnt != '0) begin
                        r_set_cnt <= r_set_cnt - SETTLE_W'(1);
                    end else begin
                        r_rd_start <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (rd_ready) begin
                        r_rd_start <= 1'b0;
                        r_tmo      <= '0;
                        r_state    <= S_WAIT_CLR;
                    end else if (w_tmo_hit) begin
                        r_err      <= 1'b1;
                        r_rd_start <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_WAIT_CLR: begin
                    if (!rd_ready) begin
                        r_state <= S_NEXT;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_counter <= w_sum[CNT_W-1:0];
                        r_pt_idx  <= r_pt_idx + 16'd1;
                        r_set_cnt <= r_settle;
                        r_state   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // A low go level is required before another sweep can start.
                    if (!go) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign counter  = r_counter;
    assign rd_start = r_rd_start;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign pt_idx   = r_pt_idx;

endmodule
